uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares the board's single UART TX line (rs232_tx_ttl) between two byte-stream requesters.
//   Requester A is the manta response path; requester B is an auxiliary debug or telemetry source.
//   Arbitrates round-robin at packet granularity, so a packet is never interleaved with the other requester's bytes.
//   Serializes each granted byte as 8N1 and drives tx directly.
// PARAMETERS
//   CLOCKS_PER_BAUD  104    clk cycles per UART bit (12 MHz / 115200); legal range >= 1
//   TIMEOUT_CYCLES   12000  idle cycles in WAIT before a held grant is revoked (TIMEOUT_EN builds only)
// PORTS
//   clk        in   1  system clock; all logic on rising edge
//   rst        in   1  synchronous reset, active-high
//   a_data     in   8  requester A byte
//   a_valid    in   1  A byte present
//   a_last     in   1  A byte is final byte of its packet
//   a_ready    out  1  A byte accepted this cycle (a_valid & a_ready)
//   b_data     in   8  requester B byte
//   b_valid    in   1  B byte present
//   b_last     in   1  B byte is final byte of its packet
//   b_ready    out  1  B byte accepted this cycle
//   tx         out  1  UART serial out, idle high
//   grant      out  2  one-hot current owner {B,A}; 2'b00 when unowned
//   busy       out  1  state != IDLE
//   timeout    out  1  1-cycle pulse when a grant is revoked by timeout (0 when TIMEOUT_EN undefined)
// BEHAVIOUR
//   - Reset values: tx=1, grant=0, busy=0, timeout=0, a_ready=b_ready=0, rr pointer favours A.
//   - FSM states: IDLE, SEND, WAIT.
//   - IDLE, arbitration:
//     - Winner = sole valid requester.
//     - If both valid: the requester not granted most recently; A wins after reset.
//     - The winner's ready is asserted combinationally in the same cycle.
//     - On handshake: latch data/last, set grant, go SEND.
//   - SEND: 10 bits (start 0, d[0]..d[7] LSB first, stop 1), each held exactly CLOCKS_PER_BAUD cycles.
//     - tx shows the start bit on the cycle after the handshake.
//     - Both readies are 0 throughout SEND.
//   - End of stop bit (last cycle of stop bit):
//     - If latched last=1: go IDLE, clear grant, rr pointer records this owner.
//     - Else: go WAIT with grant held.
//   - WAIT: ready asserted only to the grant holder; the other requester is ignored even if valid.
//     - Holder handshake: latch byte, go SEND.
//   - Byte pacing: a continuously valid holder gets back-to-back frames (1 idle-high cycle between stop and next start).
//     - Byte-to-byte period is 10*CLOCKS_PER_BAUD+1 cycles.
//   - Ready outputs are never asserted while rst=1.
//   - Data, valid and last must be held stable until the handshake.
//   - Baud counter width is $clog2(CLOCKS_PER_BAUD+1) and it wraps to 0 at each bit boundary.
//   - Bit index counts 0..9; no other state is shared between frames.
//   - Reset mid-frame: the frame is aborted, tx=1 on the next cycle, and the latched byte is discarded.
//   - Simultaneous last byte from the holder and valid from the other requester: the other requester is granted in IDLE after the stop bit.
// CONFIGURATION
//   TIMEOUT_EN defined:
//     - A cycle counter runs in WAIT and clears on each holder handshake.
//     - When it reaches TIMEOUT_CYCLES: pulse timeout for 1 cycle, clear grant, rr pointer records the holder, go IDLE.
//     - The holder's partial packet is considered terminated.
//   TIMEOUT_EN undefined:
//     - WAIT persists indefinitely; timeout is tied 0 and no counter is built.
// TESTING (bench uses CLOCKS_PER_BAUD=4, TIMEOUT_CYCLES=20)
//   1. After reset, A sends 0x55 last=1:
//      - a_ready high for exactly 1 cycle.
//      - tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
//      - busy high for 40 cycles, then grant=00.
//   2. A and B both valid in IDLE with single-byte packets:
//      - A granted first (grant=01), B second (grant=10).
//      - Repeat with both valid again: B's turn is not taken twice; order alternates A,B,A,B.
//   3. A sends 0x12 then 0x34 (last=1) while b_valid is held high:
//      - b_ready stays 0 until after 0x34's stop bit.
//      - Frames for 0x12 and 0x34 are 41 cycles apart; B's frame follows.
//   4. rst asserted during bit 3 of A's frame:
//      - Next cycle tx=1, grant=00, busy=0.
//      - After release, B-only request is granted and sent cleanly.
//   5. TIMEOUT_EN: A sends 0xAA last=0 then drops a_valid while B is valid:
//      - timeout pulses 20 cycles after entering WAIT.
//      - grant moves to 10 and B's byte is transmitted.
//   6. CLOCKS_PER_BAUD=1, A sends 0xFF last=1:
//      - tx is low for 1 cycle, then high for 9 cycles.
//      - No extra or missing bit cycles.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one 8N1 UART TX line between two byte-stream
// requesters (A = manta response path, B = auxiliary debug/telemetry).
// Arbitration is round-robin at packet granularity; a granted requester keeps
// the line until it delivers a byte marked last.
// Optional feature: define TIMEOUT_EN to revoke a grant that sits idle in
// WAIT for TIMEOUT_CYCLES cycles (pulses timeout when it happens).
module uart_tx_scheduler #(
    parameter int unsigned CLOCKS_PER_BAUD = 104,
    parameter int unsigned TIMEOUT_CYCLES  = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    input  logic       a_last,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    input  logic       b_last,
    output logic       b_ready,
    output logic       tx,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BAUD + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);

    if (CLOCKS_PER_BAUD < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_scheduler: CLOCKS_PER_BAUD and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_idx;
    logic [7:0]        data_q;
    logic              last_q;
    logic [1:0]        grant_q;
    logic              prefer_b;   // 1 when A owned the line most recently
    logic              take_a;
    logic              take_b;
    logic              bit_end;
    logic              frame_end;
    logic              to_fire;
    logic              frame_bit;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign frame_end = (state == SEND) && bit_end && (bit_idx == 4'd9);

`ifdef TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] wait_cnt;

    // Idle-cycle counter for a held grant; restarts every time WAIT is entered
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // Next-state, arbitration and handshake decode
    always_comb begin
        state_n = state;
        take_a  = 1'b0;
        take_b  = 1'b0;
        to_fire = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (a_valid && (!b_valid || !prefer_b)) begin
                        take_a = 1'b1;
                    end else if (b_valid) begin
                        take_b = 1'b1;
                    end
                end
                if (take_a || take_b) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                if (frame_end) begin
                    state_n = last_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
`ifdef TIMEOUT_EN
                if (!rst && wait_cnt == TO_LAST) begin
                    to_fire = 1'b1;
                    state_n = IDLE;
                end else
`endif
                if (!rst) begin
                    take_a = grant_q[0] & a_valid;
                    take_b = grant_q[1] & b_valid;
                    if (take_a || take_b) begin
                        state_n = SEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Baud timing and bit position within the current frame
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (take_a || take_b) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (state == SEND) begin
            if (bit_end) begin
                baud_cnt <= '0;
                bit_idx  <= frame_end ? 4'd0 : bit_idx + 4'd1;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // Byte capture, ownership and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            last_q   <= 1'b0;
            grant_q  <= '0;
            prefer_b <= 1'b0;
        end else if (take_a || take_b) begin
            data_q  <= take_a ? a_data : b_data;
            last_q  <= take_a ? a_last : b_last;
            grant_q <= {take_b, take_a};
        end else if ((frame_end && last_q) || to_fire) begin
            grant_q  <= '0;
            prefer_b <= grant_q[0];
        end
    end

    // Select the serial bit: start, LSB-first data, stop
    always_comb begin
        frame_bit = 1'b1;
        case (bit_idx)
            4'd0:    frame_bit = 1'b0;
            4'd1:    frame_bit = data_q[0];
            4'd2:    frame_bit = data_q[1];
            4'd3:    frame_bit = data_q[2];
            4'd4:    frame_bit = data_q[3];
            4'd5:    frame_bit = data_q[4];
            4'd6:    frame_bit = data_q[5];
            4'd7:    frame_bit = data_q[6];
            4'd8:    frame_bit = data_q[7];
            default: frame_bit = 1'b1;
        endcase
    end

    assign tx      = (state == SEND) ? frame_bit : 1'b1;
    assign a_ready = take_a;
    assign b_ready = take_b;
    assign grant   = grant_q;
    assign busy    = (state != IDLE);
    assign timeout = to_fire;

endmodule
